// File: rtl/lanectrl_pause_pkg.sv
// Shared types and default timing constants for the lane-control pause request generator.
package lanectrl_pause_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        UPD,
        POST,
        HOLD
    } state_t;

    localparam int DEF_PRE_CYCLES     = 4;
    localparam int DEF_POST_CYCLES    = 4;
    localparam int DEF_HOLDOFF_CYCLES = 8;
    localparam int DEF_CODE_W         = 8;
    localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/lanectrl_pause_cnt.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module lanectrl_pause_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lanectrl_pause_req_gen.sv
// Accepts one delay-code update at a time and wraps it in a fixed-width clock pause
// followed by a holdoff gap; all outputs are registered.
module lanectrl_pause_req_gen
    import lanectrl_pause_pkg::*;
#(
    parameter int PRE_CYCLES     = DEF_PRE_CYCLES,
    parameter int POST_CYCLES    = DEF_POST_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CODE_W         = DEF_CODE_W,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              UPDATE_REQ,
    input  logic [CODE_W-1:0] CODE_IN,
    output logic              UPDATE_ACK,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DELAY_UPDATE,
    output logic [CODE_W-1:0] CODE_OUT,
    output logic              DONE,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES);
    localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             leave_pause;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    lanectrl_pause_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        leave_pause  = 1'b0;
        // HOLD with an empty counter only occurs when the holdoff is zero: DONE cycle may accept.
        accept       = UPDATE_REQ && cnt_zero && ((state == IDLE) || (state == HOLD));

        case (state)
            IDLE: ;
            PRE: begin
                cnt_dec = 1'b1;
                if (cnt == CNT_ONE) state_next = UPD;
            end
            UPD: begin
                if (POST_CYCLES == 0) begin
                    leave_pause = 1'b1;
                end else begin
                    state_next   = POST;
                    cnt_load     = 1'b1;
                    cnt_load_val = POST_LD;
                end
            end
            POST: begin
                cnt_dec = 1'b1;
                if (cnt == CNT_ONE) leave_pause = 1'b1;
            end
            HOLD: begin
                cnt_dec = 1'b1;
                if (cnt_zero || (cnt == CNT_ONE)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (leave_pause) begin
            state_next   = HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LD;
        end

        if (accept) begin
            if (PRE_CYCLES == 0) begin
                state_next = UPD;
            end else begin
                state_next   = PRE;
                cnt_load     = 1'b1;
                cnt_load_val = PRE_LD;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            UPDATE_ACK      <= 1'b0;
            HS_IO_CLK_PAUSE <= 1'b0;
            DELAY_UPDATE    <= 1'b0;
            DONE            <= 1'b0;
            BUSY            <= 1'b0;
            // NOTE: the code register is reset too so the delay line never sees an undefined code.
            CODE_OUT        <= '0;
        end else begin
            state           <= state_next;
            UPDATE_ACK      <= accept;
            HS_IO_CLK_PAUSE <= (state_next == PRE) || (state_next == UPD) || (state_next == POST);
            DELAY_UPDATE    <= (state_next == UPD);
            DONE            <= leave_pause;
            BUSY            <= (state_next != IDLE);
            if (accept) CODE_OUT <= CODE_IN;
        end
    end

endmodule

// File: tb/tb_lanectrl_pause_req_gen.sv
// Scoreboard bench: stimulus queues timed output events, per-DUT monitors pop and compare them.
module tb_lanectrl_pause_req_gen;

    localparam int EV_ACK        = 0;
    localparam int EV_BUSY_RISE  = 1;
    localparam int EV_PAUSE_RISE = 2;
    localparam int EV_UPD        = 3;
    localparam int EV_PAUSE_FALL = 4;
    localparam int EV_DONE       = 5;
    localparam int EV_BUSY_FALL  = 6;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] code;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT0: default timing; DUT1: zero pre/post/holdoff.
    logic       rst0, req0, ack0, pause0, upd0, done0, busy0;
    logic [7:0] code_in0, code_out0;
    logic       rst1, req1, ack1, pause1, upd1, done1, busy1;
    logic [7:0] code_in1, code_out1;

    lanectrl_pause_req_gen dut0 (
        .CLK             (clk),
        .RESET           (rst0),
        .UPDATE_REQ      (req0),
        .CODE_IN         (code_in0),
        .UPDATE_ACK      (ack0),
        .HS_IO_CLK_PAUSE (pause0),
        .DELAY_UPDATE    (upd0),
        .CODE_OUT        (code_out0),
        .DONE            (done0),
        .BUSY            (busy0)
    );

    lanectrl_pause_req_gen #(
        .PRE_CYCLES     (0),
        .POST_CYCLES    (0),
        .HOLDOFF_CYCLES (0)
    ) dut1 (
        .CLK             (clk),
        .RESET           (rst1),
        .UPDATE_REQ      (req1),
        .CODE_IN         (code_in1),
        .UPDATE_ACK      (ack1),
        .HS_IO_CLK_PAUSE (pause1),
        .DELAY_UPDATE    (upd1),
        .CODE_OUT        (code_out1),
        .DONE            (done1),
        .BUSY            (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int kind, input int at, input logic [7:0] code);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.code = code;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Full sequence accepted on sample cycle base; busy_fall=0 when a re-accept keeps BUSY high.
    task automatic push_seq(input int id, input int base, input int pre, input int post,
                            input int hold, input logic [7:0] code,
                            input bit busy_rise, input bit busy_fall);
        int done_at;
        done_at = base + pre + post + 2;
        push(id, EV_ACK, base + 1, 8'h00);
        if (busy_rise) push(id, EV_BUSY_RISE, base + 1, 8'h00);
        push(id, EV_PAUSE_RISE, base + 1, 8'h00);
        push(id, EV_UPD, base + pre + 1, code);
        push(id, EV_PAUSE_FALL, done_at, 8'h00);
        push(id, EV_DONE, done_at, 8'h00);
        if (busy_fall) push(id, EV_BUSY_FALL, done_at + ((hold == 0) ? 1 : hold), 8'h00);
    endtask

    task automatic observe(input int id, input int kind, input logic [7:0] code);
        ev_t e;
        bit  empty;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected event: kind %0d at cycle %0d, none expected", id, kind, cyc);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            check($sformatf("dut%0d event kind", id), kind, e.kind);
            check($sformatf("dut%0d event %0d cycle", id, kind), cyc, e.cyc);
            if (kind == EV_UPD) check($sformatf("dut%0d update code", id), {24'h0, code}, {24'h0, e.code});
        end
    endtask

    logic prev_pause0 = 1'b0, prev_busy0 = 1'b0;
    logic prev_pause1 = 1'b0, prev_busy1 = 1'b0;

    always @(negedge clk) begin
        if (ack0)                  observe(0, EV_ACK, 8'h00);
        if (busy0 && !prev_busy0)  observe(0, EV_BUSY_RISE, 8'h00);
        if (pause0 && !prev_pause0) observe(0, EV_PAUSE_RISE, 8'h00);
        if (upd0)                  observe(0, EV_UPD, code_out0);
        if (!pause0 && prev_pause0) observe(0, EV_PAUSE_FALL, 8'h00);
        if (done0)                 observe(0, EV_DONE, 8'h00);
        if (!busy0 && prev_busy0)  observe(0, EV_BUSY_FALL, 8'h00);
        if (ack0 || upd0 || done0)
            check("dut0 ack/upd/done exclusive", 32'(ack0) + 32'(upd0) + 32'(done0), 32'd1);
        prev_pause0 = pause0;
        prev_busy0  = busy0;
    end

    always @(negedge clk) begin
        if (ack1)                  observe(1, EV_ACK, 8'h00);
        if (busy1 && !prev_busy1)  observe(1, EV_BUSY_RISE, 8'h00);
        if (pause1 && !prev_pause1) observe(1, EV_PAUSE_RISE, 8'h00);
        if (upd1)                  observe(1, EV_UPD, code_out1);
        if (!pause1 && prev_pause1) observe(1, EV_PAUSE_FALL, 8'h00);
        if (done1)                 observe(1, EV_DONE, 8'h00);
        if (!busy1 && prev_busy1)  observe(1, EV_BUSY_FALL, 8'h00);
        prev_pause1 = pause1;
        prev_busy1  = busy1;
    end

    task automatic go_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int b1, b, c, r;
        rst0 = 1'b1; req0 = 1'b0; code_in0 = 8'h00;
        rst1 = 1'b1; req1 = 1'b0; code_in1 = 8'h00;
        @(negedge clk);

        check("dut0 reset ACK",   {31'h0, ack0},   0);
        check("dut0 reset PAUSE", {31'h0, pause0}, 0);
        check("dut0 reset UPD",   {31'h0, upd0},   0);
        check("dut0 reset DONE",  {31'h0, done0},  0);
        check("dut0 reset BUSY",  {31'h0, busy0},  0);
        check("dut0 reset CODE",  {24'h0, code_out0}, 0);
        check("dut1 reset PAUSE", {31'h0, pause1}, 0);
        check("dut1 reset BUSY",  {31'h0, busy1},  0);
        check("dut1 reset CODE",  {24'h0, code_out1}, 0);

        go_cycle(2);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Zero-timing instance: request held, re-accepted in the DONE cycle.
        b1 = cyc + 1;
        go_cycle(b1);
        push_seq(1, b1,     0, 0, 0, 8'h11, 1'b1, 1'b0);
        push_seq(1, b1 + 2, 0, 0, 0, 8'h22, 1'b0, 1'b1);
        req1 = 1'b1;
        code_in1 = 8'h11;
        go_cycle(b1 + 2);
        code_in1 = 8'h22;
        go_cycle(b1 + 3);
        req1 = 1'b0;
        go_cycle(b1 + 8);

        // Default instance: held request gives back-to-back sequences separated by holdoff.
        b = cyc + 1;
        go_cycle(b);
        push_seq(0, b,      4, 4, 8, 8'hA5, 1'b1, 1'b1);
        push_seq(0, b + 18, 4, 4, 8, 8'h3C, 1'b1, 1'b1);
        req0 = 1'b1;
        code_in0 = 8'hA5;
        go_cycle(b + 3);
        code_in0 = 8'h3C;
        for (int k = b + 3; k <= b + 10; k++) begin
            go_cycle(k);
            check("dut0 CODE_OUT held mid-pause", {24'h0, code_out0}, 32'hA5);
        end
        go_cycle(b + 19);
        check("dut0 CODE_OUT second capture", {24'h0, code_out0}, 32'h3C);
        req0 = 1'b0;

        // One-cycle request pulse inside holdoff must be ignored.
        go_cycle(b + 30);
        req0 = 1'b1;
        go_cycle(b + 31);
        req0 = 1'b0;

        // Asynchronous reset in the middle of the pause.
        c = b + 40;
        go_cycle(c);
        push(0, EV_ACK,        c + 1, 8'h00);
        push(0, EV_BUSY_RISE,  c + 1, 8'h00);
        push(0, EV_PAUSE_RISE, c + 1, 8'h00);
        push(0, EV_UPD,        c + 5, 8'h5A);
        push(0, EV_PAUSE_FALL, c + 7, 8'h00);
        push(0, EV_BUSY_FALL,  c + 7, 8'h00);
        req0 = 1'b1;
        code_in0 = 8'h5A;
        go_cycle(c + 1);
        req0 = 1'b0;
        go_cycle(c + 6);
        #1 rst0 = 1'b1;
        #1;
        check("dut0 async reset PAUSE", {31'h0, pause0}, 0);
        check("dut0 async reset BUSY",  {31'h0, busy0},  0);
        check("dut0 async reset CODE",  {24'h0, code_out0}, 0);

        // After release a request is accepted at once, with no holdoff.
        r = c + 8;
        go_cycle(r);
        rst0 = 1'b0;
        push_seq(0, r, 4, 4, 8, 8'h77, 1'b1, 1'b1);
        req0 = 1'b1;
        code_in0 = 8'h77;
        go_cycle(r + 1);
        req0 = 1'b0;
        go_cycle(r + 22);

        check("dut0 expected events all seen", q0.size(), 0);
        check("dut1 expected events all seen", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
